// File: rtl/keypad_pkg.sv
// Shared keypad definitions: responder state encoding, key-code field split
// and the active-low all-released row constant.
package keypad_pkg;

    typedef enum logic [4:0] {
        S_IDLE       = 5'b00001,
        S_BOUNCE_IN  = 5'b00010,
        S_HOLD       = 5'b00100,
        S_BOUNCE_OUT = 5'b01000,
        S_GAP        = 5'b10000
    } state_t;

    localparam logic [3:0] ROWS_RELEASED = 4'hF;

    function automatic logic [1:0] key_row(input logic [3:0] key);
        return key[3:2];
    endfunction

    function automatic logic [1:0] key_col(input logic [3:0] key);
        return key[1:0];
    endfunction

endpackage

// File: rtl/keypad_responder_tick_gen.sv
// Timing tick source: free-running modulo-TICK_DIV counter that can be
// restarted so the first tick lands exactly TICK_DIV cycles later.
module tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_responder.sv
// Keypad emulator at the matrix pins: plays back press commands as a
// bouncing contact that pulls one row low while its column is selected.
module keypad_responder
    import keypad_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int BOUNCE_TICKS = 4,
    parameter int GAP_TICKS    = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_key,
    input  logic [7:0] cmd_hold,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] BT = 8'(BOUNCE_TICKS);
    localparam logic [7:0] GT = 8'(GAP_TICKS);

    state_t     state;
    logic       contact;
    logic [3:0] key;
    logic [7:0] hold;
    logic [7:0] dur;
    logic [3:0] col_meta;
    logic [3:0] col_sync;
    logic [3:0] row_next;
    logic [7:0] hold_eff;
    logic       tick;
    logic       accept;
    logic       last;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = ~cmd_ready;
    assign accept    = cmd_valid && cmd_ready;
    assign hold_eff  = (cmd_hold == 8'd0) ? 8'd1 : cmd_hold;
    assign last      = (dur <= 8'd1);

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk(clk),
        .rst(rst),
        .restart(accept),
        .tick(tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            contact <= 1'b0;
            key     <= '0;
            hold    <= '0;
            dur     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        key     <= cmd_key;
                        hold    <= hold_eff;
                        contact <= 1'b1;
                        if (BT != 8'd0) begin
                            state <= S_BOUNCE_IN;
                            dur   <= BT;
                        end else begin
                            state <= S_HOLD;
                            dur   <= hold_eff;
                        end
                    end
                end
                S_BOUNCE_IN: begin
                    if (tick) begin
                        if (last) begin
                            state   <= S_HOLD;
                            contact <= 1'b1;
                            dur     <= hold;
                        end else begin
                            contact <= ~contact;
                            dur     <= dur - 8'd1;
                        end
                    end
                end
                S_HOLD: begin
                    if (tick) begin
                        if (last) begin
                            contact <= 1'b0;
                            if (BT != 8'd0) begin
                                state <= S_BOUNCE_OUT;
                                dur   <= BT;
                            end else begin
                                state <= S_GAP;
                                dur   <= GT;
                            end
                        end else begin
                            dur <= dur - 8'd1;
                        end
                    end
                end
                S_BOUNCE_OUT: begin
                    if (tick) begin
                        if (last) begin
                            state   <= S_GAP;
                            contact <= 1'b0;
                            dur     <= GT;
                        end else begin
                            contact <= ~contact;
                            dur     <= dur - 8'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (tick) begin
                        if (last) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end else begin
                            dur <= dur - 8'd1;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    contact <= 1'b0;
                end
            endcase
        end
    end

    // An idle scanner (all columns low) still sees the closed key's row.
    always_comb begin
        row_next = ROWS_RELEASED;
        if (contact && !col_sync[key_col(key)]) begin
            row_next[key_row(key)] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_meta <= '0;
            col_sync <= '0;
            row      <= ROWS_RELEASED;
        end else begin
            col_meta <= col;
            col_sync <= col_meta;
            row      <= row_next;
        end
    end

endmodule

// File: tb/tb_keypad_responder.sv
// Directed bench for keypad_responder: per-cycle row/done/busy scoreboard
// built from a tick-period contact model, plus scan, hold-0 and reset cases.
module tb_keypad_responder;

    localparam int TD = 4;
    localparam int GT = 2;
    localparam int B1 = 2;

    typedef struct packed {
        logic [3:0] row;
        logic       done;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] col = 4'h0;
    logic       v0 = 1'b0;
    logic       v1 = 1'b0;
    logic [3:0] key_in = 4'h0;
    logic [7:0] hold_in = 8'h0;
    logic [3:0] row0, row1;
    logic       rdy0, rdy1, busy0, busy1, done0, done1;

    exp_t       sb[$];
    logic [3:0] plan [64];
    int         vecs = 0;
    int         errs = 0;

    always #5 clk = ~clk;

    keypad_responder #(
        .TICK_DIV(TD), .BOUNCE_TICKS(0), .GAP_TICKS(GT)
    ) dut0 (
        .clk(clk), .rst(rst), .col(col), .row(row0),
        .cmd_valid(v0), .cmd_ready(rdy0), .cmd_key(key_in),
        .cmd_hold(hold_in), .busy(busy0), .done(done0)
    );

    keypad_responder #(
        .TICK_DIV(TD), .BOUNCE_TICKS(B1), .GAP_TICKS(GT)
    ) dut1 (
        .clk(clk), .rst(rst), .col(col), .row(row1),
        .cmd_valid(v1), .cmd_ready(rdy1), .cmd_key(key_in),
        .cmd_hold(hold_in), .busy(busy1), .done(done1)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [3:0] r_of(input int i);
        return (i != 0) ? row1 : row0;
    endfunction

    function automatic logic [3:0] y_of(input int i);
        return {3'b0, (i != 0) ? rdy1 : rdy0};
    endfunction

    function automatic logic [3:0] b_of(input int i);
        return {3'b0, (i != 0) ? busy1 : busy0};
    endfunction

    function automatic logic [3:0] d_of(input int i);
        return {3'b0, (i != 0) ? done1 : done0};
    endfunction

    // Contact level in cycle j after the accepting edge.
    function automatic logic contact_at(input int j, input int bt, input int h);
        int p;
        if (j < 0) return 1'b0;
        p = j / TD;
        if (p < bt) return (p % 2) == 0;
        if (p < bt + h) return 1'b1;
        if (p < 2 * bt + h) return ((p - bt - h) % 2) == 1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] want);
        vecs++;
        assert (got === want) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int inst, input logic [3:0] key, input logic [7:0] h);
        key_in  = key;
        hold_in = h;
        if (inst != 0) v1 = 1'b1;
        else v0 = 1'b1;
        for (int i = 0; i < 64 && y_of(inst) != 4'h1; i++) step();
        chk("send_ready", y_of(inst), 4'h1);
        step();
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    // Called one step after the accepting edge; checks n cycles.
    task automatic check_press(input string tag, input int inst,
                               input logic [3:0] key, input logic [7:0] h,
                               input int bt, input int n, input int inj_k,
                               input logic [3:0] ik, input logic [7:0] ih);
        int hh;
        int dk;
        exp_t e;
        logic [3:0] cv;
        hh = (h == 8'd0) ? 1 : int'(h);
        dk = (2 * bt + hh + GT) * TD;
        for (int kk = 0; kk < n; kk++) begin
            e.row = 4'hF;
            cv = plan[(kk >= 3) ? kk - 3 : 0];
            if (contact_at(kk - 1, bt, hh) && !cv[key[1:0]]) e.row[key[3:2]] = 1'b0;
            e.done = (kk == dk);
            e.busy = (kk < dk);
            sb.push_back(e);
        end
        for (int kk = 0; kk < n; kk++) begin
            col = plan[kk];
            if (kk == inj_k) begin
                key_in  = ik;
                hold_in = ih;
                if (inst != 0) v1 = 1'b1;
                else v0 = 1'b1;
            end
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("%s k%0d row", tag, kk), r_of(inst), e.row);
            chk($sformatf("%s k%0d done", tag, kk), d_of(inst), {3'b0, e.done});
            chk($sformatf("%s k%0d busy", tag, kk), b_of(inst), {3'b0, e.busy});
            step();
        end
    endtask

    initial begin
        logic [3:0] found_r;
        logic [3:0] found_c;
        logic [3:0] cv;
        int w;

        repeat (3) step();
        rst = 1'b1;

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("reset row", row0, 4'hF);
            chk("reset ready", {3'b0, rdy0}, 4'h1);
            chk("reset busy", {3'b0, busy0}, 4'h0);
            chk("reset done", {3'b0, done0 | done1}, 4'h0);
            step();
        end
        chk("reset row1", row1, 4'hF);

        for (int i = 0; i < 64; i++) begin
            plan[i] = (i < 8) ? 4'hE : (i < 16) ? 4'hD : (i < 24) ? 4'hB : 4'h7;
        end
        col = 4'hE;
        repeat (3) step();
        send(0, 4'b0000, 8'd3);
        check_press("colstep", 0, 4'b0000, 8'd3, 0, 32, -1, 4'h0, 8'd0);

        for (int i = 0; i < 64; i++) plan[i] = 4'h0;
        col = 4'h0;
        repeat (3) step();
        send(0, 4'b1101, 8'd2);
        check_press("idle_col", 0, 4'b1101, 8'd2, 0, 20, -1, 4'h0, 8'd0);

        send(0, 4'b1101, 8'd20);
        found_r = 4'hF;
        found_c = 4'hF;
        for (int c = 0; c < 4; c++) begin
            cv = 4'hF;
            cv[c] = 1'b0;
            col = cv;
            repeat (4) @(posedge clk);
            @(negedge clk);
            if (row0 != 4'hF) begin
                found_r = row0;
                found_c = cv;
            end
        end
        chk("scan row", found_r, 4'h7);
        chk("scan col", found_c, 4'hD);
        col = 4'h0;
        for (w = 0; w < 400 && !done0; w++) @(negedge clk);
        chk("scan done seen", {3'b0, done0}, 4'h1);
        step();

        send(0, 4'b0110, 8'd0);
        check_press("hold0", 0, 4'b0110, 8'd0, 0, 16, -1, 4'h0, 8'd0);

        send(0, 4'b0101, 8'd1);
        check_press("busy_a", 0, 4'b0101, 8'd1, 0, 13, 2, 4'b1010, 8'd1);
        v0 = 1'b0;
        check_press("busy_b", 0, 4'b1010, 8'd1, 0, 16, -1, 4'h0, 8'd0);

        send(1, 4'b1000, 8'd1);
        check_press("bounce", 1, 4'b1000, 8'd1, B1, 32, -1, 4'h0, 8'd0);

        send(1, 4'b1000, 8'd5);
        repeat (12) step();
        chk("pre_rst row", row1, 4'b1011);
        rst = 1'b0;
        #1;
        chk("rst row", row1, 4'hF);
        chk("rst busy", {3'b0, busy1}, 4'h0);
        chk("rst ready", {3'b0, rdy1}, 4'h1);
        repeat (5) begin
            @(negedge clk);
            chk("rst_low done", {3'b0, done1}, 4'h0);
        end
        step();
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("post_rst row", row1, 4'hF);
            chk("post_rst done", {3'b0, done1}, 4'h0);
            chk("post_rst busy", {3'b0, busy1}, 4'h0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/keypad_responder.md
# keypad_responder

Emulates a 4x4 membrane keypad at the matrix pins: it watches the column lines driven by the keypad scanner and drives the row lines as a physical key would. Key presses come in as commands over a valid/ready handshake, each with a hold duration. Contact bounce and a release gap are modelled as well. Used in hardware-in-loop and on-board self-test, where a CPU or UART bridge replaces the physical keypad in front of the keyboard scanner.

## Interface
- `TICK_DIV`, 50000: clk cycles per timing tick (1 ms at 50 MHz); must be ≥ 2.
- `BOUNCE_TICKS`, 4: ticks of contact bounce at press start and at release; 0 disables bounce.
- `GAP_TICKS`, 30: minimum released ticks after a press before the next command is accepted.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `col`  in  4  column lines from the scanner, active-low select.
- `row`  out  4  row lines to the scanner, active-low, registered.
- `cmd_valid`  in  1  press command present.
- `cmd_ready`  out  1  responder can accept a command.
- `cmd_key`  in  4  key code: row index in [3:2], column index in [1:0].
- `cmd_hold`  in  8  hold time in ticks; 0 is treated as 1.
- `busy`  out  1  high from accept until the gap ends.
- `done`  out  1  one-cycle pulse when the gap ends.

## Operation
- **Accept.** A command is accepted on a rising clk edge with `cmd_valid && cmd_ready`. On accept, key and hold are latched internally. Inputs are ignored at all other times.
- **Column sync.** `col` passes through a 2-flop synchronizer before use.
- **Contact model.** The key at (r,c) is "closed" when `contact` = 1. The registered `row` output follows:
  - `row[r]` = 0 when `contact` and `col_sync[c]` = 0.
  - Every other row bit = 1.
- **State machine.** One-hot states:
  - IDLE: `contact`=0, `cmd_ready`=1. Goes to BOUNCE_IN on accept.
  - BOUNCE_IN: `contact` toggles on each tick, starting at 1, for `BOUNCE_TICKS` ticks, then goes to HOLD with `contact`=1. With `BOUNCE_TICKS`=0 this state is skipped.
  - HOLD: `contact`=1 for max(`cmd_hold`,1) ticks, then goes to BOUNCE_OUT.
  - BOUNCE_OUT: toggles starting at 0 for `BOUNCE_TICKS` ticks, then goes to GAP with `contact`=0.
  - GAP: `contact`=0 for `GAP_TICKS` ticks. Then pulse `done` and return to IDLE.
- **Busy/ready.** `busy` = not IDLE. `cmd_ready` = IDLE.
- **Tick generator.**
  - Free-running counter modulo `TICK_DIV`; `tick` is a one-cycle pulse when the counter wraps.
  - The counter restarts at 0 on accept, so the first tick comes exactly `TICK_DIV` cycles after accept.
- **Duration counter.** 8 bits wide. It is loaded at each state entry and decremented on `tick`; the state exits on the tick where it reaches 1.
- **Rows.** Only one row bit is ever low. The key code maps directly to row/column indices, with no lookup.

## Timing
- **Reset values:**
  - `row` = 4'hF.
  - `cmd_ready` = 1.
  - `busy` = 0.
  - `done` = 0.
  - State is IDLE; the synchronizer flops and all counters are 0.
- **Accept to `busy`/`cmd_ready` change:** 1 cycle after the accepting edge.
- **`col` change to `row` response:** 3 clk cycles (2 sync + 1 output register).
- **`contact` change to `row` response:** 1 cycle.
- **Total press time from accept to `done`:** (2·`BOUNCE_TICKS` + max(hold,1) + `GAP_TICKS`)·`TICK_DIV` cycles, ±1 cycle.
- **`done`** is high for exactly one cycle, in the same cycle that `cmd_ready` returns to 1. A command presented in that same cycle is accepted on the next edge.
- **`cmd_valid` while busy** has no effect. There is no queue.
- **`col` = 4'h0** (scanner idle): `row[r]` reads 0 whenever `contact` = 1. This is required so the scanner leaves its no-key state.
- **Reset asserted mid-press:** `row` goes to 4'hF immediately (asynchronously), and the state returns to IDLE. No `done` is generated.

## Structure
- Shared package `keypad_pkg`:
  - State encodings.
  - The key-code field split (row index [3:2], column index [1:0]).
  - The active-low all-released constant 4'hF.
  - The same package is used by the scanner-side decoder.
- One sub-module, `tick_gen`: `TICK_DIV` counter with synchronous restart and a `tick` pulse output.

## Test plan
All scenarios use `TICK_DIV`=4, `BOUNCE_TICKS`=0, `GAP_TICKS`=2 unless stated otherwise.
- **Reset check.** Release `rst` and hold idle for 100 cycles → `row`=F, `cmd_ready`=1, `busy`=0, `done` never pulses.
- **Key 4'b0000, hold 3, with col stepping.** Drive `col`=E, then D, B, 7, each for 8 cycles → `row`=E only during `col`=E (3-cycle lag); otherwise F. `done` arrives 20±1 cycles after accept.
- **Key 4'b1101, hold 2, `col`=0 idle.** → `row`=7 for 8 cycles, then F. Start the full 4x4 scanner afterwards → it reports row 7 / col D.
- **Hold 0.** → behaves exactly as hold 1: `row` is low for 4 cycles.
- **Second command during busy, then at the `done` cycle.** → the first is ignored; the second is accepted on the edge after `done`.
- **Bounce: `BOUNCE_TICKS`=2, hold 1, `col`=0.** → `row[r]` pattern is 0,1 | 0 | 1,0 | 1, each for 4 cycles. Assert `rst` mid-HOLD → `row`=F in the same cycle, state is IDLE.
